nz_bitmap_pack: RTL and testbench
=================================

// Module: nz_bitmap_pack
// PURPOSE
//  Inverse of the non-zero address generator: rebuilds the SPAD_WIDTH-bit occupancy bitmap of one feature row
//  from a stream of beats, each carrying up to DIM non-zero bit addresses.
//  Sits on the PE-row write-back path: it packs sparse addresses from the PEs back into dense 1-bit feature rows
//  for the spad/output buffer. It also reports the non-zero count and a sticky duplicate-address error per row.
// PARAMETERS
//  DIM         4                      address lanes per input beat
//  SPAD_WIDTH  64                     bitmap width (row length)
//  ADDR_WIDTH  `C_LOG_2(SPAD_WIDTH)   per-lane address width (6)
//  CNT_WIDTH   `C_LOG_2(SPAD_WIDTH)+1 width of non-zero count (7; holds 0..64)
// PORTS
//  clk           in   1                 single clock, rising edge
//  reset         in   1                 synchronous, active-high
//  in_valid      in   1                 input beat valid
//  in_ready      out  1                 input beat accepted when in_valid & in_ready
//  in_addr_bus   in   ADDR_WIDTH*DIM    lane 0 in MSBs: lane i = [ADDR_WIDTH*(DIM-i)-1 -: ADDR_WIDTH]
//  in_lane_vld   in   DIM               bit i qualifies lane i; any pattern legal, incl. all-zero
//  in_last       in   1                 beat closes the current row
//  out_valid     out  1                 packed row available
//  out_ready     in   1                 downstream accepts row when out_valid & out_ready
//  out_bitmap    out  SPAD_WIDTH        bit a set iff address a was received in the row
//  out_nnz       out  CNT_WIDTH         popcount of out_bitmap
//  out_dup_err   out  1                 row contained a repeated address (in-beat or across beats)
// BEHAVIOUR
//  - Reset (synchronous): state=IDLE, accumulator=0, nnz/dup accumulators=0, out_valid=0, out_bitmap=0, out_nnz=0,
//    out_dup_err=0. A reset mid-row discards the partial row. A reset while out_valid=1 drops the held row.
//  - FSM states: IDLE (accumulator empty) and ACCUM (at least one beat of the row accepted).
//    IDLE->ACCUM on an accepted beat with in_last=0. ACCUM->IDLE on an accepted beat with in_last=1.
//    IDLE->IDLE on an accepted beat with in_last=1 (single-beat row).
//  - in_ready = !out_valid | out_ready (one output register, no extra buffering). This is combinational from
//    out_ready and is identical in both states.
//  - Per accepted beat: new = OR over valid lanes of one-hot(addr). acc <= acc | new (cleared when the beat is last).
//    nnz_acc += popcount(new & ~acc).
//    dup flag is set if (new & acc)!=0, or if two valid lanes in the beat carry the same address.
//  - Last beat: out_bitmap <= acc|new, out_nnz <= final count, out_dup_err <= final dup flag, out_valid <= 1.
//    Accumulators are cleared in the same cycle. Latency: row visible 1 cycle after the last beat is accepted.
//  - Non-last beats are accepted while out_valid=1 only if in_ready=1. Accumulation of the next row never corrupts
//    the held outputs.
//  - out_valid clears when out_ready=1 and there is no simultaneous last-beat acceptance. If both happen in the
//    same cycle, out_valid stays 1 and the outputs load the new row (back-to-back, one row per cycle max).
//  - Empty row (single last beat with in_lane_vld=0): bitmap=0, nnz=0, dup=0.
//  - Duplicates are idempotent for bitmap and nnz; only out_dup_err reports them.
//  - Outputs are stable while out_valid=1 and out_ready=0.
// STRUCTURE
//  - Shared header nz_defs.vh: DIM, SPAD_WIDTH, ADDR_WIDTH and CNT_WIDTH defaults, plus the lane-slice macro.
//    The address generator uses the same header.
//  - Sub-module nz_addr_decode: DIM lane addresses + lane valids -> OR'd one-hot vector and in-beat duplicate flag
//    (purely combinational).
//  - Top level: FSM, accumulator, popcount adder, and output register with handshake.
// TESTING
//  1 Single beat: lanes {3,10,40,63} all valid, last=1 -> next cycle out_bitmap=bits 3,10,40,63; nnz=4; dup=0.
//  2 Two beats, {0,1,2,3} then {60,61,-,-} (vld=4'b1100, last) -> bitmap 0x3000_0000_0000_000F; nnz=6.
//  3 Duplicate: beat {5,5,7,7} vld=1111 last -> bitmap bits 5,7; nnz=2; dup=1.
//    Then cross-beat {9} then {9} last -> nnz=1, dup=1.
//  4 Backpressure: out_ready=0 for 5 cycles after a row; a non-last beat is blocked (in_ready=0);
//    outputs stay constant. Raise out_ready -> row consumed, next row starts.
//  5 Back-to-back: single-beat last rows every cycle with out_ready=1 -> out_valid stays 1 and a new bitmap appears
//    each cycle, none lost.
//  6 Reset mid-row after 2 beats, then one row {12} last -> bitmap only bit 12, nnz=1. An empty last beat -> bitmap 0,
//    nnz 0.

Source files
------------

// File: rtl/nz_bitmap_pack_pkg.sv
`default_nettype none
// ============================================================================
// nz_bitmap_pack_pkg : shared sizes, FSM encoding and lane-slice helper
// Rev 1.0
// ============================================================================
package nz_bitmap_pack_pkg;

   localparam int C_DIM        = 4;
   localparam int C_SPAD_WIDTH = 64;
   localparam int C_ADDR_WIDTH = $clog2(C_SPAD_WIDTH);
   localparam int C_CNT_WIDTH  = $clog2(C_SPAD_WIDTH) + 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   // Lane 0 sits in the MSBs of the address bus.
   function automatic int lane_lsb(input int lane, input int dim, input int addr_width);
      return addr_width * (dim - 1 - lane);
   endfunction

endpackage
`default_nettype wire

// File: rtl/nz_bitmap_pack_if.sv
`default_nettype none
// ============================================================================
// nz_bitmap_pack_if : beat input and packed-row output handshakes
// Rev 1.0
// ============================================================================
interface nz_bitmap_pack_if
   import nz_bitmap_pack_pkg::*;
#(
   parameter int DIM        = C_DIM,
   parameter int SPAD_WIDTH = C_SPAD_WIDTH
);
   localparam int ADDR_WIDTH = $clog2(SPAD_WIDTH);
   localparam int CNT_WIDTH  = $clog2(SPAD_WIDTH) + 1;

   logic                       in_valid;
   logic                       in_ready;
   logic [ADDR_WIDTH*DIM-1:0]  in_addr_bus;
   logic [DIM-1:0]             in_lane_vld;
   logic                       in_last;
   logic                       out_valid;
   logic                       out_ready;
   logic [SPAD_WIDTH-1:0]      out_bitmap;
   logic [CNT_WIDTH-1:0]       out_nnz;
   logic                       out_dup_err;

   modport master (
      output in_valid, in_addr_bus, in_lane_vld, in_last, out_ready,
      input  in_ready, out_valid, out_bitmap, out_nnz, out_dup_err
   );

   modport slave (
      input  in_valid, in_addr_bus, in_lane_vld, in_last, out_ready,
      output in_ready, out_valid, out_bitmap, out_nnz, out_dup_err
   );

endinterface
`default_nettype wire

// File: rtl/nz_bitmap_pack_addr_decode.sv
`default_nettype none
// ============================================================================
// nz_addr_decode : lane addresses -> OR'd one-hot row vector + in-beat dup flag
// Rev 1.0
// ============================================================================
module nz_addr_decode
   import nz_bitmap_pack_pkg::*;
#(
   parameter int DIM        = C_DIM,
   parameter int SPAD_WIDTH = C_SPAD_WIDTH
) (
   input  logic [$clog2(SPAD_WIDTH)*DIM-1:0] addr_bus,
   input  logic [DIM-1:0]                    lane_vld,
   output logic [SPAD_WIDTH-1:0]             onehot,
   output logic                              dup
);
   localparam int ADDR_WIDTH = $clog2(SPAD_WIDTH);
   localparam logic [SPAD_WIDTH-1:0] C_ONE = SPAD_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] w_addr [DIM];

   for (genvar i = 0; i < DIM; i++) begin : g_lane
      assign w_addr[i] = addr_bus[lane_lsb(i, DIM, ADDR_WIDTH) +: ADDR_WIDTH];
   end

   always_comb begin
      onehot = '0;
      for (int i = 0; i < DIM; i++) begin
         if (lane_vld[i]) begin
            onehot = onehot | (C_ONE << w_addr[i]);
         end
      end
   end

   // Only pairs of qualified lanes count; garbage on idle lanes is ignored.
   always_comb begin
      dup = 1'b0;
      for (int i = 0; i < DIM; i++) begin
         for (int j = i + 1; j < DIM; j++) begin
            if (lane_vld[i] && lane_vld[j] && (w_addr[i] == w_addr[j])) begin
               dup = 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/nz_bitmap_pack.sv
`default_nettype none
// ============================================================================
// nz_bitmap_pack : rebuilds a dense occupancy bitmap row from address beats
// Rev 1.0
// ============================================================================
module nz_bitmap_pack
   import nz_bitmap_pack_pkg::*;
#(
   parameter int DIM        = C_DIM,
   parameter int SPAD_WIDTH = C_SPAD_WIDTH
) (
   input  logic            clk,
   input  logic            reset,
   nz_bitmap_pack_if.slave bus
);
   localparam int CNT_WIDTH = $clog2(SPAD_WIDTH) + 1;

   state_t                r_state;
   state_t                w_state_nxt;

   logic [SPAD_WIDTH-1:0] r_acc;
   logic [SPAD_WIDTH-1:0] w_acc_eff;
   logic [SPAD_WIDTH-1:0] w_new;
   logic [SPAD_WIDTH-1:0] w_fresh;
   logic [CNT_WIDTH-1:0]  r_nnz_acc;
   logic [CNT_WIDTH-1:0]  w_new_cnt;
   logic [CNT_WIDTH-1:0]  w_nnz_total;
   logic                  r_dup_acc;
   logic                  w_dec_dup;
   logic                  w_beat_dup;

   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_row_done;

   logic                  r_out_valid;
   logic [SPAD_WIDTH-1:0] r_out_bitmap;
   logic [CNT_WIDTH-1:0]  r_out_nnz;
   logic                  r_out_dup;

   nz_addr_decode #(
      .DIM        (DIM),
      .SPAD_WIDTH (SPAD_WIDTH)
   ) u_decode (
      .addr_bus (bus.in_addr_bus),
      .lane_vld (bus.in_lane_vld),
      .onehot   (w_new),
      .dup      (w_dec_dup)
   );

   // Single output register: a new beat may enter whenever the held row leaves.
   assign w_in_ready = !r_out_valid || bus.out_ready;
   assign w_accept   = bus.in_valid && w_in_ready;
   assign w_row_done = w_accept && bus.in_last;

   // The accumulator is empty by construction in IDLE; masking makes that explicit.
   assign w_acc_eff  = (r_state == ST_ACCUM) ? r_acc : '0;
   assign w_fresh    = w_new & ~w_acc_eff;
   assign w_beat_dup = w_dec_dup || (|(w_new & w_acc_eff));

   always_comb begin
      w_new_cnt = '0;
      for (int i = 0; i < SPAD_WIDTH; i++) begin
         w_new_cnt = w_new_cnt + CNT_WIDTH'(w_fresh[i]);
      end
   end

   assign w_nnz_total = ((r_state == ST_ACCUM) ? r_nnz_acc : '0) + w_new_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && !bus.in_last) begin
               w_state_nxt = ST_ACCUM;
            end
         end
         ST_ACCUM: begin
            if (w_row_done) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc     <= '0;
         r_nnz_acc <= '0;
         r_dup_acc <= 1'b0;
      end else if (w_accept) begin
         if (bus.in_last) begin
            r_acc     <= '0;
            r_nnz_acc <= '0;
            r_dup_acc <= 1'b0;
         end else begin
            r_acc     <= w_acc_eff | w_new;
            r_nnz_acc <= w_nnz_total;
            r_dup_acc <= ((r_state == ST_ACCUM) && r_dup_acc) || w_beat_dup;
         end
      end
   end

   // A last beat reloads the row even when the held one is consumed this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid  <= 1'b0;
         r_out_bitmap <= '0;
         r_out_nnz    <= '0;
         r_out_dup    <= 1'b0;
      end else if (w_row_done) begin
         r_out_valid  <= 1'b1;
         r_out_bitmap <= w_acc_eff | w_new;
         r_out_nnz    <= w_nnz_total;
         r_out_dup    <= ((r_state == ST_ACCUM) && r_dup_acc) || w_beat_dup;
      end else if (bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_bitmap  = r_out_bitmap;
   assign bus.out_nnz     = r_out_nnz;
   assign bus.out_dup_err = r_out_dup;

endmodule
`default_nettype wire

// File: tb/tb_nz_bitmap_pack.sv
`default_nettype none
// ============================================================================
// tb_nz_bitmap_pack : directed vector table plus handshake/reset sequences
// Rev 1.0
// ============================================================================
module tb_nz_bitmap_pack;
   import nz_bitmap_pack_pkg::*;

   logic clk = 1'b0;
   logic reset;
   int   n_pass = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   nz_bitmap_pack_if #(.DIM(4), .SPAD_WIDTH(64)) nz_if ();

   nz_bitmap_pack #(.DIM(4), .SPAD_WIDTH(64)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (nz_if.slave)
   );

   typedef struct {
      logic [5:0]  a [4];
      logic [3:0]  vld;
      logic        last;
      logic [63:0] bm;
      logic [6:0]  nnz;
      logic        dup;
   } vec_t;

   function automatic vec_t mk(input logic [5:0] a0, a1, a2, a3, input logic [3:0] vld,
                               input logic last, input logic [63:0] bm, input logic [6:0] nnz,
                               input logic dup);
      vec_t v;
      v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
      v.vld = vld; v.last = last; v.bm = bm; v.nnz = nnz; v.dup = dup;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   task automatic drive(input vec_t v);
      for (int i = 0; i < 4; i++) nz_if.in_addr_bus[6*(4-i)-1 -: 6] = v.a[i];
      nz_if.in_lane_vld = v.vld;
      nz_if.in_last     = v.last;
      nz_if.in_valid    = 1'b1;
   endtask

   // One beat presented for a single cycle; returns on the negedge after acceptance.
   task automatic send(input vec_t v);
      @(negedge clk);
      drive(v);
      @(negedge clk);
      nz_if.in_valid = 1'b0;
   endtask

   task automatic chk_row(input string name, input logic [63:0] bm, input logic [6:0] nnz,
                          input logic dup);
      chk({name, ".valid"},  64'(nz_if.out_valid), 64'd1);
      chk({name, ".bitmap"}, nz_if.out_bitmap, bm);
      chk({name, ".nnz"},    64'(nz_if.out_nnz), 64'(nnz));
      chk({name, ".dup"},    64'(nz_if.out_dup_err), 64'(dup));
   endtask

   vec_t        tbl [13];
   vec_t        v;
   logic [63:0] held;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = mk(3, 10, 40, 63, 4'b1111, 1, 64'h8000_0100_0000_0408, 4, 0);
      tbl[1]  = mk(0, 1, 2, 3,    4'b1111, 0, 0, 0, 0);
      tbl[2]  = mk(0, 0, 60, 61,  4'b1100, 1, 64'h3000_0000_0000_000F, 6, 0);
      tbl[3]  = mk(5, 5, 7, 7,    4'b1111, 1, 64'h0000_0000_0000_00A0, 2, 1);
      tbl[4]  = mk(9, 0, 0, 0,    4'b0001, 0, 0, 0, 0);
      tbl[5]  = mk(9, 0, 0, 0,    4'b0001, 1, 64'h0000_0000_0000_0200, 1, 1);
      tbl[6]  = mk(33, 33, 33, 34, 4'b1001, 1, 64'h0000_0006_0000_0000, 2, 0);
      tbl[7]  = mk(44, 45, 46, 47, 4'b0000, 0, 0, 0, 0);
      tbl[8]  = mk(20, 20, 8, 8,  4'b0010, 1, 64'h0000_0000_0010_0000, 1, 0);
      tbl[9]  = mk(1, 2, 3, 4,    4'b0000, 1, 64'h0, 0, 0);
      tbl[10] = mk(7, 0, 0, 0,    4'b0001, 0, 0, 0, 0);
      tbl[11] = mk(0, 8, 0, 0,    4'b0010, 0, 0, 0, 0);
      tbl[12] = mk(7, 8, 7, 0,    4'b0100, 1, 64'h0000_0000_0000_0180, 2, 1);

      nz_if.in_valid    = 1'b0;
      nz_if.in_addr_bus = '0;
      nz_if.in_lane_vld = '0;
      nz_if.in_last     = 1'b0;
      nz_if.out_ready   = 1'b1;
      reset             = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("rst.valid",    64'(nz_if.out_valid), 64'd0);
      chk("rst.bitmap",   nz_if.out_bitmap, 64'd0);
      chk("rst.nnz",      64'(nz_if.out_nnz), 64'd0);
      chk("rst.dup",      64'(nz_if.out_dup_err), 64'd0);
      chk("rst.in_ready", 64'(nz_if.in_ready), 64'd1);

      for (int k = 0; k < 13; k++) begin
         send(tbl[k]);
         if (tbl[k].last) chk_row($sformatf("vec%0d", k), tbl[k].bm, tbl[k].nnz, tbl[k].dup);
      end

      // Backpressure: held row must not move while the next row is blocked.
      @(negedge clk);
      nz_if.out_ready = 1'b0;
      send(mk(1, 2, 3, 4, 4'b1111, 1, 0, 0, 0));
      held = 64'h0000_0000_0000_001E;
      chk_row("bp.row", held, 4, 0);
      drive(mk(50, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp.in_ready", 64'(nz_if.in_ready), 64'd0);
         chk("bp.valid",    64'(nz_if.out_valid), 64'd1);
         chk("bp.bitmap",   nz_if.out_bitmap, held);
      end
      nz_if.out_ready = 1'b1;
      @(negedge clk);
      chk("bp.drain", 64'(nz_if.out_valid), 64'd0);
      drive(mk(51, 0, 0, 0, 4'b0001, 1, 0, 0, 0));
      @(negedge clk);
      nz_if.in_valid = 1'b0;
      chk_row("bp.next", 64'h000C_0000_0000_0000, 2, 0);

      // Back-to-back single-beat rows: one new bitmap per cycle.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k > 0) chk_row($sformatf("b2b%0d", k), 64'd1 << (9 + k), 1, 0);
         if (k < 5) drive(mk(6'(10 + k), 0, 0, 0, 4'b0001, 1, 0, 0, 0));
         else nz_if.in_valid = 1'b0;
      end

      // Reset mid-row discards the partial accumulation.
      send(mk(40, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
      send(mk(41, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mrst.valid",  64'(nz_if.out_valid), 64'd0);
      chk("mrst.bitmap", nz_if.out_bitmap, 64'd0);
      send(mk(12, 0, 0, 0, 4'b0001, 1, 0, 0, 0));
      chk_row("mrst.row", 64'h0000_0000_0000_1000, 1, 0);
      v = mk(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0);
      send(v);
      chk_row("mrst.empty", 64'd0, 0, 0);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
